bch_bm_iter_p: RTL and testbench
================================

Name: bch_bm_iter_p

Overview:
- Parametrised, iterative inversionless Berlekamp-Massey solver for binary BCH codes over GF(2^M) with correction capability T.
- Sits between the syndrome block and the Chien search.
- Takes 2T syndromes through a valid/ready handshake and returns the error-locator coefficients lambda_0..lambda_T, the locator degree and an uncorrectable flag.
- Successor to the fixed 3-stage t=2 GF(16) solver: any M/T, flow control, failure detection.

Parameters:
- M, 4, field degree (symbols are M bits).
- T, 2, correctable errors; number of BM iterations.
- PRIM_POLY, 5'b10011, primitive polynomial (M+1 bits, x^4+x+1 by default).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  syndromes valid
- in_ready  out  1  block idle, accepts syndromes
- synd  in  2T*M  S_1..S_2T; S_j at bits [j*M-1:(j-1)*M]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- lambda  out  (T+1)*M  Λ_0..Λ_T; Λ_i at bits [(i+1)*M-1:i*M]
- deg  out  $clog2(2T)  final register L
- fail  out  1  uncorrectable pattern

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; out_valid=0, lambda=0, deg=0, fail=0; internal Λ, B, γ, L, k cleared.
- in_ready = (state==IDLE).
- FSM states: IDLE, DISC, UPD, DONE (NORM when the optional feature is on).
- IDLE:
  - Capture on in_valid&&in_ready: latch synd.
  - Init: Λ=1, B=1, γ=1, L=0, k=0. Go to DISC.
- DISC: register Δ = Σ_{i=0..T+1} Λ_i·S_{2k+1-i}, with S_j=0 for j<1. Go to UPD.
- UPD:
  - Λ ← γ·Λ + Δ·x·B.
  - If Δ≠0 and L≤k: B ← x·Λ_old, γ ← Δ, L ← 2k+1−L.
  - Else: B ← x²·B.
  - k ← k+1.
  - If k==T go to DONE, else go to DISC.
- Storage width: Λ and B hold T+2 coefficients (0..T+1). Higher terms are discarded.
- Arithmetic: all products are GF(2^M) mod PRIM_POLY; sums are XOR.
- DONE:
  - out_valid=1.
  - lambda = Λ_0..Λ_T; deg = L.
  - fail = (L>T) or (Λ_{T+1}≠0) or (Λ_0==0).
- Hold: outputs stay stable while out_valid && !out_ready.
- Release: on out_valid&&out_ready, go to IDLE, drop out_valid and keep the output values.
- Latency: out_valid rises 2T clock edges after the accepting edge (4 for T=2). Next accept is possible the cycle after release.
- Scaling: without normalisation the result is the true locator times a nonzero constant; roots are unchanged.
- in_valid outside IDLE is ignored; synd may change freely after capture.
- Reset mid-operation aborts the computation. No out_valid appears for the aborted word.

Optional Feature:
- Macro: BCH_BM_NORMALIZE_EN.
- When defined:
  - Extra state NORM between the last UPD and DONE.
  - NORM multiplies every Λ_i by Λ_0^{-1}, so lambda_0=1 and the output is the true locator.
  - Inverse computed combinationally (a^(2^M−2)).
  - Latency becomes 2T+1.
  - If Λ_0==0: normalisation is skipped and fail=1.
- When undefined: no NORM state; the scaled locator is output, with latency 2T.

Decomposition:
- Package bch_gf_pkg holds:
  - MAX_M constant.
  - Default primitive polynomials per M.
  - gf_mul(a,b,poly) and gf_inv(a,poly) functions over MAX_M bits.
  - FSM state enum.
- One sub-module, bm_coef_pe: per-coefficient update element computing γ·Λ_i ⊕ Δ·B_{i−1}. It is instantiated T+2 times by generate.

Test Plan (M=4, T=2, x^4+x+1, α=2):
- Single error at position 3, synd S1..S4 = 8,C,A,F:
  - Without macro: lambda = 8,C,0; deg=1; fail=0.
  - With macro: lambda = 1,8,0.
- Errors at positions 1 and 4, synd = 1,1,7,1: lambda = 1,1,6 (both builds); deg=2; fail=0; out_valid 4 edges after accept (5 with macro).
- All-zero syndromes: lambda = 1,0,0; deg=0; fail=0.
- Uncorrectable, synd = 0,0,1,0: L=3, so fail=1, deg=3; lambda = 1,0,0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0, in_valid pulses ignored.
  - Then out_ready=1 for one cycle: in_ready=1 the next cycle.
  - Back-to-back words produce the correct results in order.
- Reset mid-operation: assert rst=0 during UPD of the two-error word. Outputs are zero immediately (asynchronous), no out_valid follows, and the next accepted word computes correctly.

Source files
------------

// File: rtl/bch_gf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bch_gf_pkg
//  Purpose  : GF(2^m) helpers and FSM encoding shared by the iterative
//             Berlekamp-Massey solver (bch_bm_iter_p) and its update element.
//  Revision : 1.0 - initial release
// ============================================================================
package bch_gf_pkg;

    // Widest field the helper functions support; narrower fields are
    // zero-extended into this width by the callers.
    localparam int MAX_M = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DISC = 3'd1,
        ST_UPD  = 3'd2,
        ST_NORM = 3'd3,
        ST_DONE = 3'd4
    } bm_state_t;

    // Common primitive polynomials, bit m set for x^m (MAX_M+1 bits wide).
    function automatic logic [MAX_M:0] gf_default_poly(input int m);
        case (m)
            2:       return 17'h00007;
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            16:      return 17'h1100B;
            default: return 17'h00000;
        endcase
    endfunction

    // Degree of the field polynomial = index of its highest set bit.
    function automatic int gf_degree(input logic [MAX_M:0] poly);
        int d;
        d = 0;
        for (int i = 0; i <= MAX_M; i++) begin
            if (poly[i]) d = i;
        end
        return d;
    endfunction

    // Shift-and-add product, reduced on the fly so the partial result
    // never reaches x^deg.
    function automatic logic [MAX_M-1:0] gf_mul(input logic [MAX_M-1:0] a,
                                                input logic [MAX_M-1:0] b,
                                                input logic [MAX_M:0]   poly);
        int              d;
        logic [MAX_M:0]  r;
        d = gf_degree(poly);
        r = '0;
        for (int i = MAX_M - 1; i >= 0; i--) begin
            r = r << 1;
            if (r[d]) r = r ^ poly;
            if (b[i]) r = r ^ {1'b0, a};
        end
        return MAX_M'(r);
    endfunction

    // a^(2^m-2) = prod_{i=1..m-1} a^(2^i); zero maps to zero.
    function automatic logic [MAX_M-1:0] gf_inv(input logic [MAX_M-1:0] a,
                                                input logic [MAX_M:0]   poly);
        int                d;
        logic [MAX_M-1:0]  s;
        logic [MAX_M-1:0]  r;
        d = gf_degree(poly);
        s = a;
        r = MAX_M'(1);
        for (int i = 1; i < MAX_M; i++) begin
            s = gf_mul(s, s, poly);
            if (i < d) r = gf_mul(r, s, poly);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bm_coef_pe.sv
`default_nettype none
// ============================================================================
//  Module   : bm_coef_pe
//  Purpose  : One locator-coefficient update: lam_nxt = gamma*lam ^ delta*b_prev
//             over GF(2^M) reduced by PRIM_POLY.
//  Revision : 1.0 - initial release
// ============================================================================
module bm_coef_pe
    import bch_gf_pkg::*;
#(
    parameter int         M         = 4,
    parameter logic [M:0] PRIM_POLY = 5'b10011
)(
    input  logic [M-1:0] gamma,
    input  logic [M-1:0] lam,
    input  logic [M-1:0] delta,
    input  logic [M-1:0] b_prev,
    output logic [M-1:0] lam_nxt
);

    localparam logic [MAX_M:0] c_poly_ext = (MAX_M+1)'(PRIM_POLY);

    function automatic logic [M-1:0] mul_m(input logic [M-1:0] a, input logic [M-1:0] b);
        return M'(gf_mul(MAX_M'(a), MAX_M'(b), c_poly_ext));
    endfunction

    // Scaled old coefficient plus discrepancy-weighted shifted correction term.
    always_comb begin
        lam_nxt = mul_m(gamma, lam) ^ mul_m(delta, b_prev);
    end

endmodule
`default_nettype wire

// File: rtl/bch_bm_iter_p.sv
`default_nettype none
// ============================================================================
//  Module   : bch_bm_iter_p
//  Purpose  : Iterative inversionless Berlekamp-Massey solver for binary BCH
//             codes, GF(2^M), T correctable errors, valid/ready on both sides.
//             One DISC + one UPD cycle per iteration, T iterations.
//  Option   : BCH_BM_NORMALIZE_EN - adds a NORM cycle scaling lambda_0 to 1.
//  Revision : 1.0 - initial release
// ============================================================================
module bch_bm_iter_p
    import bch_gf_pkg::*;
#(
    parameter int         M         = 4,
    parameter int         T         = 2,
    parameter logic [M:0] PRIM_POLY = 5'b10011
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*T*M-1:0]          synd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(T+1)*M-1:0]        lambda,
    output logic [$clog2(2*T)-1:0]    deg,
    output logic                      fail
);

    localparam int             c_nc       = T + 2;          // stored coefficients 0..T+1
    localparam int             c_kw       = $clog2(T + 1);  // iteration counter width
    localparam int             c_lw       = $clog2(2 * T);  // register-length width
    localparam logic [MAX_M:0] c_poly_ext = (MAX_M+1)'(PRIM_POLY);

    function automatic logic [M-1:0] mul_m(input logic [M-1:0] a, input logic [M-1:0] b);
        return M'(gf_mul(MAX_M'(a), MAX_M'(b), c_poly_ext));
    endfunction

    bm_state_t         r_state;
    bm_state_t         w_state_nxt;
    logic [M-1:0]      r_synd [1:2*T];
    logic [M-1:0]      r_lam  [c_nc];
    logic [M-1:0]      r_b    [c_nc];
    logic [M-1:0]      r_gamma;
    logic [M-1:0]      r_delta;
    logic [c_lw-1:0]   r_l;
    logic [c_kw-1:0]   r_k;

    logic [M-1:0]      w_ssel    [c_nc];
    logic [M-1:0]      w_lam_upd [c_nc];
    logic [M-1:0]      w_delta;
    logic [M-1:0]      w_pe_gamma;
    logic [M-1:0]      w_pe_delta;
    logic              w_take;
    logic              w_last;
    logic              w_load_out;
    logic [c_lw-1:0]   w_l_upd;
    logic [c_lw-1:0]   w_l_fin;

    assign w_take  = (r_delta != '0) && (int'(r_l) <= int'(r_k));
    assign w_l_upd = w_take ? c_lw'(2 * int'(r_k) + 1 - int'(r_l)) : r_l;
    assign w_l_fin = (r_state == ST_UPD) ? w_l_upd : r_l;
    assign w_last  = (int'(r_k) == T - 1);

    // Discrepancy: sum of lambda_i * S_(2k+1-i), syndromes below S_1 read as zero.
    always_comb begin
        w_delta = '0;
        for (int i = 0; i < c_nc; i++) begin
            w_ssel[i] = '0;
            for (int j = 1; j <= 2 * T; j++) begin
                if (j == 2 * int'(r_k) + 1 - i) w_ssel[i] = r_synd[j];
            end
            w_delta = w_delta ^ mul_m(r_lam[i], w_ssel[i]);
        end
    end

`ifdef BCH_BM_NORMALIZE_EN
    logic [M-1:0] w_inv;
    assign w_inv = M'(gf_inv(MAX_M'(r_lam[0]), c_poly_ext));
`endif

    // Update elements double as the normaliser: gamma <- 1/lambda_0, delta <- 0.
    always_comb begin
        w_pe_gamma = r_gamma;
        w_pe_delta = r_delta;
`ifdef BCH_BM_NORMALIZE_EN
        if (r_state == ST_NORM) begin
            w_pe_gamma = (r_lam[0] == '0) ? M'(1) : w_inv;
            w_pe_delta = '0;
        end
`endif
    end

    generate
        for (genvar i = 0; i < c_nc; i++) begin : g_pe
            logic [M-1:0] w_b_prev;
            if (i == 0) begin : g_first
                assign w_b_prev = '0;
            end else begin : g_rest
                assign w_b_prev = r_b[i-1];
            end
            bm_coef_pe #(.M(M), .PRIM_POLY(PRIM_POLY)) u_pe (
                .gamma   (w_pe_gamma),
                .lam     (r_lam[i]),
                .delta   (w_pe_delta),
                .b_prev  (w_b_prev),
                .lam_nxt (w_lam_upd[i])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, handshake outputs and the result-capture strobe.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_DISC;
            end
            ST_DISC: w_state_nxt = ST_UPD;
            ST_UPD: begin
                if (w_last) begin
`ifdef BCH_BM_NORMALIZE_EN
                    w_state_nxt = ST_NORM;
`else
                    w_state_nxt = ST_DONE;
                    w_load_out  = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_DISC;
                end
            end
`ifdef BCH_BM_NORMALIZE_EN
            ST_NORM: begin
                w_state_nxt = ST_DONE;
                w_load_out  = 1'b1;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, iterate, and latch the result as DONE is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 1; j <= 2 * T; j++) r_synd[j] <= '0;
            for (int i = 0; i < c_nc; i++) begin
                r_lam[i] <= '0;
                r_b[i]   <= '0;
            end
            r_gamma <= '0;
            r_delta <= '0;
            r_l     <= '0;
            r_k     <= '0;
            lambda  <= '0;
            deg     <= '0;
            fail    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int j = 1; j <= 2 * T; j++) r_synd[j] <= synd[(j-1)*M +: M];
                        for (int i = 0; i < c_nc; i++) begin
                            r_lam[i] <= (i == 0) ? M'(1) : '0;
                            r_b[i]   <= (i == 0) ? M'(1) : '0;
                        end
                        r_gamma <= M'(1);
                        r_l     <= '0;
                        r_k     <= '0;
                    end
                end
                ST_DISC: r_delta <= w_delta;
                ST_UPD: begin
                    for (int i = 0; i < c_nc; i++) r_lam[i] <= w_lam_upd[i];
                    if (w_take) begin
                        r_b[0] <= '0;
                        for (int i = 1; i < c_nc; i++) r_b[i] <= r_lam[i-1];
                        r_gamma <= r_delta;
                    end else begin
                        r_b[0] <= '0;
                        r_b[1] <= '0;
                        for (int i = 2; i < c_nc; i++) r_b[i] <= r_b[i-2];
                    end
                    r_l <= w_l_upd;
                    r_k <= r_k + c_kw'(1);
                end
                ST_NORM: begin
                    for (int i = 0; i < c_nc; i++) r_lam[i] <= w_lam_upd[i];
                end
                default: ;
            endcase
            if (w_load_out) begin
                for (int i = 0; i <= T; i++) lambda[i*M +: M] <= w_lam_upd[i];
                deg  <= w_l_fin;
                fail <= (int'(w_l_fin) > T) || (w_lam_upd[T+1] != '0) || (w_lam_upd[0] == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_bm_iter_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bch_bm_iter_p
//  Purpose  : Self-checking bench for bch_bm_iter_p (M=4, T=2, x^4+x+1):
//             directed vectors, backpressure, mid-run reset, and random error
//             patterns against a table-driven GF(16) reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bch_bm_iter_p;

    localparam int M   = 4;
    localparam int T   = 2;
    localparam int N   = 15;
    localparam int SW  = 2 * T * M;
    localparam int LMW = (T + 1) * M;
    localparam int DW  = $clog2(2 * T);
`ifdef BCH_BM_NORMALIZE_EN
    localparam int LAT = 2 * T + 1;
`else
    localparam int LAT = 2 * T;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SW-1:0]   synd;
    logic            out_valid;
    logic            out_ready;
    logic [LMW-1:0]  lambda;
    logic [DW-1:0]   deg;
    logic            fail;

    int n_checks;
    int n_fail;
    int gexp [0:N-1];
    int glog [0:N];

    bch_bm_iter_p #(.M(M), .T(T), .PRIM_POLY(5'b10011)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .synd      (synd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lambda    (lambda),
        .deg       (deg),
        .fail      (fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % N];
    endfunction

    function automatic int ginv(input int a);
        return gexp[(N - glog[a]) % N];
    endfunction

    // Reference: the BM recurrence evaluated with log/antilog tables.
    function automatic void model_bm(input logic [SW-1:0] sv, output logic [LMW-1:0] lam_pk,
                                     output int dg, output bit fl);
        int s [0:2*T];
        int lam [0:T+1];
        int b [0:T+1];
        int nl [0:T+1];
        int nb [0:T+1];
        int gam, ll, d, inv;
        s[0] = 0;
        for (int j = 1; j <= 2 * T; j++) s[j] = int'(sv[(j-1)*M +: M]);
        for (int i = 0; i <= T + 1; i++) begin
            lam[i] = (i == 0) ? 1 : 0;
            b[i]   = (i == 0) ? 1 : 0;
        end
        gam = 1;
        ll  = 0;
        for (int k = 0; k < T; k++) begin
            d = 0;
            for (int i = 0; i <= T + 1; i++)
                if (2 * k + 1 - i >= 1) d ^= gmul(lam[i], s[2*k+1-i]);
            for (int i = 0; i <= T + 1; i++)
                nl[i] = gmul(gam, lam[i]) ^ ((i > 0) ? gmul(d, b[i-1]) : 0);
            if (d != 0 && ll <= k) begin
                for (int i = 0; i <= T + 1; i++) nb[i] = (i > 0) ? lam[i-1] : 0;
                gam = d;
                ll  = 2 * k + 1 - ll;
            end else begin
                for (int i = 0; i <= T + 1; i++) nb[i] = (i > 1) ? b[i-2] : 0;
            end
            lam = nl;
            b   = nb;
        end
`ifdef BCH_BM_NORMALIZE_EN
        if (lam[0] != 0) begin
            inv = ginv(lam[0]);
            for (int i = 0; i <= T + 1; i++) lam[i] = gmul(lam[i], inv);
        end
`else
        inv = 0;
`endif
        lam_pk = '0;
        for (int i = 0; i <= T; i++) lam_pk[i*M +: M] = M'(lam[i]);
        dg = ll;
        fl = (ll > T) || (lam[T+1] != 0) || (lam[0] == 0) || (inv < 0);
    endfunction

    // Called at a negedge; returns at the negedge after the result is released.
    task automatic run_word(input string tag, input logic [SW-1:0] s, input logic [LMW-1:0] exp_lam,
                            input int exp_deg, input bit exp_fail, input int hold);
        int cnt;
        synd     = s;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        synd     = SW'($urandom);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(LAT));
        check({tag, "_lambda"}, 32'(lambda), 32'(exp_lam));
        check({tag, "_deg"}, 32'(deg), 32'(exp_deg));
        check({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_lambda"}, 32'(lambda), 32'(exp_lam));
            in_valid = h[0];
            synd     = SW'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rel_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rel_keep"}, 32'(lambda), 32'(exp_lam));
    endtask

    initial begin
        logic [LMW-1:0] el;
        int             ed;
        bit             ef;
        logic [SW-1:0]  sv;
        int             nerr, p, acc, xp, xv, v;
        int             pos [0:2];
        bit             used [0:N-1];
        bit             seen;

        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        synd      = '0;
        rst       = 1'b1;

        v = 1;
        for (int i = 0; i < N; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 'h13;
        end
        glog[0] = 0;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_lambda", 32'(lambda), 32'd0);
        check("reset_deg", 32'(deg), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_inrdy", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors: S_1 in the low nibble.
`ifdef BCH_BM_NORMALIZE_EN
        run_word("single", 16'hFAC8, 12'h081, 1, 1'b0, 0);
`else
        run_word("single", 16'hFAC8, 12'h0C8, 1, 1'b0, 0);
`endif
        run_word("double", 16'h1711, 12'h611, 2, 1'b0, 10);
        run_word("zero",   16'h0000, 12'h001, 0, 1'b0, 0);
        run_word("uncorr", 16'h0100, 12'h001, 3, 1'b1, 0);
        run_word("double2", 16'h1711, 12'h611, 2, 1'b0, 0);

        // Abort the two-error word while it is in its first update cycle.
        synd     = 16'h1711;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_lambda", 32'(lambda), 32'd0);
        check("rst_deg", 32'(deg), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_valid", 32'(seen), 32'd0);
        run_word("after_rst", 16'h1711, 12'h611, 2, 1'b0, 0);

        // Random error patterns (0..3 errors) plus occasional raw syndromes.
        for (int w = 0; w < 20; w++) begin
            sv = '0;
            if (w % 5 == 4) begin
                nerr = -1;
                sv   = SW'($urandom);
            end else begin
                nerr = $urandom_range(0, 3);
                for (int i = 0; i < N; i++) used[i] = 1'b0;
                for (int e = 0; e < nerr; e++) begin
                    p = $urandom_range(0, N - 1);
                    while (used[p]) p = $urandom_range(0, N - 1);
                    used[p] = 1'b1;
                    pos[e]  = p;
                    for (int j = 1; j <= 2 * T; j++)
                        sv[(j-1)*M +: M] = sv[(j-1)*M +: M] ^ M'(gexp[(j * p) % N]);
                end
            end
            model_bm(sv, el, ed, ef);
            run_word($sformatf("rnd%0d", w), sv, el, ed, ef, 0);
            if (nerr >= 0 && nerr <= T) begin
                check($sformatf("rnd%0d_nerr", w), 32'(deg), 32'(nerr));
                for (int e = 0; e < nerr; e++) begin
                    xv  = gexp[(N - pos[e]) % N];
                    xp  = 1;
                    acc = 0;
                    for (int i = 0; i <= T; i++) begin
                        acc ^= gmul(int'(lambda[i*M +: M]), xp);
                        xp = gmul(xp, xv);
                    end
                    check($sformatf("rnd%0d_root%0d", w, pos[e]), 32'(acc), 32'd0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
